axi_cmd_sequencer: RTL

//  Command front-end for axi_master: buffers register read/write commands in a FIFO and issues them one at a time.

---
 rtl/axi_cmd_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_cmd_sequencer.sv
// axi_cmd_sequencer
//   Command front-end for axi_master. Register read/write commands are queued
//   in a FIFO and issued one at a time. Each command gets exactly one response,
//   returned in command order on a valid/ready stream.
//
//   Optional feature: define CMD_SEQ_TIMEOUT_EN to abort a command that has
//   not completed after TIMEOUT_CYCLES cycles in WAIT. Default build: no
//   timeout, rsp_timeout tied low.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command stream (cmd_ready = FIFO not full)
//   cmd_rw/cmd_addr/cmd_wdata  command fields (1 = write, 0 = read)
//   rsp_valid/rsp_ready        response stream
//   rsp_rw/rsp_data            echoed rw; read data (0 for writes/timeouts)
//   rsp_timeout                command aborted by timeout
//   addr/write_data            to axi_master, stable from issue to next pop
//   start_read/start_write     to axi_master, one-cycle pulses
//   done/read_data             from axi_master
//   busy                       command in flight or queued
//   cmd_count                  FIFO occupancy (excludes in-flight command)
module axi_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rw,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_rw,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_timeout,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          start_read,
  output logic                          start_write,
  input  logic                          done,
  input  logic [DATA_WIDTH-1:0]         read_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axi_cmd_sequencer: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra MSB so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         rd_entry;
  logic                  rd_rw;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_wdata;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & ~empty;
  assign cmd_count = wr_ptr - rd_ptr;
  assign busy      = (state != IDLE) | ~empty;

  assign rd_entry  = mem[rd_ptr[PW-1:0]];
  assign rd_rw     = rd_entry[EW-1];
  assign rd_addr   = rd_entry[EW-2 -: ADDR_WIDTH];
  assign rd_wdata  = rd_entry[DATA_WIDTH-1:0];

  always_ff @(posedge M_AXI_ACLK) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic cur_rw;
  logic done_q;
  logic completion;

  // Only a rising edge of done completes a command, so a level left high by
  // axi_master cannot complete the following command as well.
  assign completion = done & ~done_q;

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      cur_rw        <= 1'b0;
      done_q        <= 1'b0;
      addr          <= '0;
      write_data    <= '0;
      start_read    <= 1'b0;
      start_write   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rw        <= 1'b0;
      rsp_data      <= '0;
`ifdef CMD_SEQ_TIMEOUT_EN
      tmo_cnt       <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      done_q      <= done;
      start_read  <= 1'b0;
      start_write <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_rw      <= rd_rw;
            addr        <= rd_addr;
            write_data  <= rd_wdata;
            // Registered here so the pulse is high for exactly the ISSUE cycle.
            start_write <= rd_rw;
            start_read  <= ~rd_rw;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CMD_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (completion) begin
            rsp_valid     <= 1'b1;
            rsp_rw        <= cur_rw;
            rsp_data      <= cur_rw ? '0 : read_data;
`ifdef CMD_SEQ_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            state         <= RESP;
          end
`ifdef CMD_SEQ_TIMEOUT_EN
          // Abort after TIMEOUT_CYCLES cycles spent in WAIT.
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid     <= 1'b1;
            rsp_rw        <= cur_rw;
            rsp_data      <= '0;
            rsp_timeout_q <= 1'b1;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
